// File: rtl/xadac_pkg.sv
// Shared types for the xadac vector-bias coprocessor slice: lane geometry,
// bias opcodes and the decode/execute channel payloads.
package xadac_pkg;

  localparam int VecLanes    = 8;
  localparam int VecSumWidth = 16;
  localparam int VecLenWidth = 4;
  localparam int XLen        = 32;
  localparam int IdWidth     = 4;

  typedef logic [VecSumWidth-1:0]                VecSumT;
  typedef logic [VecLenWidth-1:0]                VecLenT;
  typedef logic [IdWidth-1:0]                    IdT;
  typedef logic [VecLanes-1:0][VecSumWidth-1:0]  VecDataT;

  typedef enum logic [2:0] {
    VB_BCAST = 3'b000,
    VB_SETB  = 3'b001,
    VB_LOADB = 3'b010,
    VB_APPLY = 3'b011
  } VbiasOpE;

  typedef struct packed {
    IdT              id;
    logic [XLen-1:0] instr;
  } dec_req_t;

  typedef struct packed {
    IdT         id;
    logic       accept;
    logic       rd_clobber;
    logic       vd_clobber;
    logic [1:0] rs_read;
    logic [2:0] vs_read;
  } dec_rsp_t;

  typedef struct packed {
    IdT                   id;
    logic [XLen-1:0]      instr;
    logic [1:0][XLen-1:0] rs_data;
    logic [2:0][VecLanes-1:0][VecSumWidth-1:0] vs_data;
  } exe_req_t;

  typedef struct packed {
    IdT              id;
    logic [XLen-1:0] rd_data;
    VecDataT         vd_data;
  } exe_rsp_t;

  // Lengths beyond the physical lane count collapse to a full vector.
  function automatic VecLenT clamp_vlen(input VecLenT raw);
    return (raw > VecLenT'(VecLanes)) ? VecLenT'(VecLanes) : raw;
  endfunction

endpackage

// File: rtl/xadac_if.sv
// Decode and execute request/response channels between core and coprocessor.
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid, dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid, dec_rsp_ready;
  dec_rsp_t dec_rsp;
  logic     exe_req_valid, exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid, exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
           exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
           exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
           exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
           exe_req_ready, exe_rsp_valid, exe_rsp
  );
endinterface

// File: rtl/xadac_vbias_lane.sv
// One lane of vs + bias, sign-extended by one bit, optionally clamped.
module xadac_vbias_lane #(
  parameter int Width    = 16,
  parameter bit Saturate = 1
) (
  input  logic [Width-1:0] vs,
  input  logic [Width-1:0] bias,
  output logic [Width-1:0] sum
);

  logic [Width:0] wide;
  assign wide = {vs[Width-1], vs} + {bias[Width-1], bias};

  // Top two bits disagree only on signed overflow; wide[Width] is the true sign.
  always_comb begin
    sum = wide[Width-1:0];
    if (Saturate && (wide[Width] != wide[Width-1]))
      sum = wide[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
  end

endmodule

// File: rtl/xadac_vbias_seq.sv
// Vector bias unit: stateless decode, serialised chunked execute with a
// per-lane bias register file.
module xadac_vbias_seq
  import xadac_pkg::*;
#(
  parameter int LanesPerCycle = 4,
  parameter bit Saturate      = 1
) (
  input  logic   clk,
  input  logic   rst,
  xadac_if.slv   slv
);

  localparam int NumChunks = VecLanes / LanesPerCycle;
  localparam int ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  logic [2:0] dec_f3;
  assign dec_f3            = slv.dec_req.instr[14:12];
  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_rsp_valid && slv.dec_rsp_ready;

  always_comb begin
    slv.dec_rsp    = '0;
    slv.dec_rsp.id = slv.dec_req.id;
    case (VbiasOpE'(dec_f3))
      VB_BCAST: begin
        slv.dec_rsp.accept     = 1'b1;
        slv.dec_rsp.vd_clobber = 1'b1;
        slv.dec_rsp.rs_read[0] = 1'b1;
      end
      VB_SETB: begin
        slv.dec_rsp.accept     = 1'b1;
        slv.dec_rsp.rs_read[0] = 1'b1;
      end
      VB_LOADB: begin
        slv.dec_rsp.accept     = 1'b1;
        slv.dec_rsp.vs_read[0] = 1'b1;
      end
      VB_APPLY: begin
        slv.dec_rsp.accept     = 1'b1;
        slv.dec_rsp.vd_clobber = 1'b1;
        slv.dec_rsp.vs_read[0] = 1'b1;
      end
      default: ;
    endcase
  end

  state_e              state_q, state_d;
  logic [ChunkW-1:0]   cnt_q;
  IdT                  id_q;
  logic [2:0]          op_q;
  VecLenT              vlen_q;
  VecSumT              rs0_q;
  VecDataT             vs0_q, bias_q, bias_d, vd_q, vd_d;
  logic                busy_done;

  // Chunk-major views so the lane array can pick its slice with cnt_q.
  logic [NumChunks-1:0][LanesPerCycle-1:0][VecSumWidth-1:0] vs_ch, bias_ch;
  VecSumT lane_sum [LanesPerCycle];
  assign vs_ch   = vs0_q;
  assign bias_ch = bias_q;

  for (genvar l = 0; l < LanesPerCycle; l++) begin : g_lane
    xadac_vbias_lane #(.Width(VecSumWidth), .Saturate(Saturate)) u_lane (
      .vs   (vs_ch[cnt_q][l]),
      .bias (bias_ch[cnt_q][l]),
      .sum  (lane_sum[l])
    );
  end

  // vlen = 0 still satisfies this on the first BUSY cycle.
  assign busy_done = ((int'(cnt_q) + 1) * LanesPerCycle) >= int'(vlen_q);

  always_comb begin
    state_d           = state_q;
    slv.exe_req_ready = 1'b0;
    slv.exe_rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        slv.exe_req_ready = 1'b1;
        if (slv.exe_req_valid) state_d = S_BUSY;
      end
      S_BUSY: if (busy_done) state_d = S_RESP;
      S_RESP: begin
        slv.exe_rsp_valid = 1'b1;
        if (slv.exe_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bias_d = bias_q;
    vd_d   = vd_q;
    if (state_q == S_BUSY) begin
      for (int i = 0; i < VecLanes; i++) begin
        if (ChunkW'(i / LanesPerCycle) == cnt_q && VecLenT'(i) < vlen_q) begin
          case (VbiasOpE'(op_q))
            VB_BCAST: vd_d[i]   = rs0_q;
            VB_SETB:  bias_d[i] = rs0_q;
            VB_LOADB: bias_d[i] = vs0_q[i];
            VB_APPLY: vd_d[i]   = lane_sum[i % LanesPerCycle];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      vlen_q  <= '0;
      rs0_q   <= '0;
      vs0_q   <= '0;
      bias_q  <= '0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      bias_q  <= bias_d;
      if (state_q == S_IDLE && slv.exe_req_valid) begin
        id_q   <= slv.exe_req.id;
        op_q   <= slv.exe_req.instr[14:12];
        vlen_q <= clamp_vlen(slv.exe_req.instr[25 +: VecLenWidth]);
        rs0_q  <= slv.exe_req.rs_data[0][VecSumWidth-1:0];
        vs0_q  <= slv.exe_req.vs_data[0];
        cnt_q  <= '0;
        vd_q   <= '0;
      end else begin
        vd_q <= vd_d;
        if (state_q == S_BUSY) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    slv.exe_rsp         = '0;
    slv.exe_rsp.id      = id_q;
    slv.exe_rsp.vd_data = vd_q;
  end

endmodule

// File: tb/tb_xadac_vbias_seq.sv
// Directed and randomized checks of xadac_vbias_seq against a lane-array model.
module tb_xadac_vbias_seq;
  import xadac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] mbias [VecLanes];

  always #5 clk = ~clk;

  xadac_if bus ();

  xadac_vbias_seq #(.LanesPerCycle(4), .Saturate(1)) dut (
    .clk (clk),
    .rst (rst),
    .slv (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input int vl);
    logic [31:0] r = $urandom;
    r[14:12] = f3;
    r[28:25] = vl[3:0];
    return r;
  endfunction

  // Reference: apply the op to lanes below the clamped length, saturating APPLY.
  function automatic VecDataT model_exe(input logic [2:0] op, input int vlen_raw,
                                        input logic [31:0] rs0, input VecDataT vs);
    VecDataT vd = '0;
    int n = (vlen_raw > VecLanes) ? VecLanes : vlen_raw;
    int s;
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd0: vd[i] = rs0[15:0];
        3'd1: mbias[i] = rs0[15:0];
        3'd2: mbias[i] = vs[i];
        3'd3: begin
          s = int'($signed(vs[i])) + int'($signed(mbias[i]));
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          vd[i] = s[15:0];
        end
        default: ;
      endcase
    end
    return vd;
  endfunction

  task automatic run_op(input logic [3:0] id, input logic [2:0] op, input int vlen_raw,
                        input logic [31:0] rs0, input VecDataT vs, input int hold);
    VecDataT exp;
    int vl, lat, explat;
    @(negedge clk);
    check("req_ready_idle", bus.exe_req_ready, 1'b1);
    bus.exe_req_valid         = 1'b1;
    bus.exe_req.id            = id;
    bus.exe_req.instr         = mk_instr(op, vlen_raw);
    bus.exe_req.rs_data[0]    = rs0;
    bus.exe_req.rs_data[1]    = $urandom;
    bus.exe_req.vs_data[0]    = vs;
    bus.exe_req.vs_data[1]    = {4{$urandom}};
    bus.exe_req.vs_data[2]    = {4{$urandom}};
    exp = model_exe(op, vlen_raw, rs0, vs);
    vl = (vlen_raw > VecLanes) ? VecLanes : vlen_raw;
    explat = ((vl == 0) ? 1 : (vl + 3) / 4) + 1;
    @(negedge clk);
    bus.exe_req_valid = 1'b0;
    lat = 1;
    while (!bus.exe_rsp_valid && lat < 32) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, explat);
    check("rsp_id", bus.exe_rsp.id, id);
    check("rsp_vd", bus.exe_rsp.vd_data, exp);
    check("rsp_rd_zero", bus.exe_rsp.rd_data, 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.exe_rsp_valid, 1'b1);
      check("hold_vd", bus.exe_rsp.vd_data, exp);
      check("hold_req_ready", bus.exe_req_ready, 1'b0);
    end
    bus.exe_rsp_ready = 1'b1;
    @(negedge clk);
    bus.exe_rsp_ready = 1'b0;
    check("rsp_drop", bus.exe_rsp_valid, 1'b0);
  endtask

  task automatic dec_check(input logic [2:0] f3);
    logic [7:0] expf, obsf;
    logic [3:0] id = 4'($urandom);
    logic       rdy = 1'($urandom);
    @(negedge clk);
    bus.dec_req_valid = 1'b1;
    bus.dec_rsp_ready = rdy;
    bus.dec_req.id    = id;
    bus.dec_req.instr = mk_instr(f3, $urandom_range(0, 15));
    #1;
    expf = {f3 < 3'd4, 1'b0, (f3 == 3'd0 || f3 == 3'd3), 1'b0,
            (f3 == 3'd0 || f3 == 3'd1), 2'b00, (f3 == 3'd2 || f3 == 3'd3)};
    obsf = {bus.dec_rsp.accept, bus.dec_rsp.rd_clobber, bus.dec_rsp.vd_clobber,
            bus.dec_rsp.rs_read, bus.dec_rsp.vs_read};
    check("dec_flags", obsf, expf);
    check("dec_id", bus.dec_rsp.id, id);
    check("dec_valid", bus.dec_rsp_valid, 1'b1);
    check("dec_ready", bus.dec_req_ready, rdy);
    bus.dec_req_valid = 1'b0;
  endtask

  initial begin
    VecDataT vs;
    for (int i = 0; i < VecLanes; i++) mbias[i] = '0;
    bus.dec_req_valid = 1'b0;
    bus.dec_req       = '0;
    bus.dec_rsp_ready = 1'b0;
    bus.exe_req_valid = 1'b0;
    bus.exe_req       = '0;
    bus.exe_rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", bus.exe_rsp_valid, 1'b0);
    check("rst_vd", bus.exe_rsp.vd_data, 0);
    check("rst_id", bus.exe_rsp.id, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.exe_req_ready, 1'b1);

    // Decode table, including invalid codes
    for (int f = 0; f < 8; f++) dec_check(3'(f));

    // BCAST truncates rs0 to the lane width
    run_op(4'd7, 3'd0, 5, 32'h0001_0003, '0, 0);

    // SETB then saturating APPLY
    run_op(4'd1, 3'd1, 8, 32'h0000_0010, '0, 0);
    for (int i = 0; i < VecLanes; i++) vs[i] = 16'h7FF8;
    run_op(4'd2, 3'd3, 8, 32'h0, vs, 1);

    // Partial LOADB leaves upper bias lanes untouched
    run_op(4'd3, 3'd1, 8, 32'h0, '0, 0);
    for (int i = 0; i < VecLanes; i++) vs[i] = 16'(i + 1);
    run_op(4'd4, 3'd2, 3, 32'h0, vs, 0);
    run_op(4'd5, 3'd3, 8, 32'h0, '0, 0);

    // vlen = 0 with a stalled response
    run_op(4'd6, 3'd3, 0, 32'h0, vs, 5);

    // Reset mid-BUSY abandons a SETB and clears bias
    @(negedge clk);
    bus.exe_req_valid      = 1'b1;
    bus.exe_req.id         = 4'd9;
    bus.exe_req.instr      = mk_instr(3'd1, 8);
    bus.exe_req.rs_data[0] = 32'h0000_0055;
    @(negedge clk);
    bus.exe_req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", bus.exe_rsp_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < VecLanes; i++) mbias[i] = '0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_rsp", bus.exe_rsp_valid, 1'b0);
      check("midrst_idle", bus.exe_req_ready, 1'b1);
    end
    for (int i = 0; i < VecLanes; i++) vs[i] = 16'd5;
    run_op(4'd10, 3'd3, 8, 32'h0, vs, 0);

    // Random ops, including invalid codes and oversize lengths
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < VecLanes; i++) vs[i] = 16'($urandom);
      run_op(4'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 15),
             $urandom, vs, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xadac_vbias_seq.md
XADAC_VBIAS_SEQ -- requirements
Module: xadac_vbias_seq

Interface
REQ-001 SHALL have parameter LanesPerCycle, default 4, meaning lanes processed per BUSY cycle; it must divide VecLanes.
REQ-002 SHALL have parameter Saturate, default 1, meaning 1 = signed-saturating APPLY, 0 = wrapping APPLY.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port slv, xadac_if.slv modport, meaning the decode and execute request/response channels.
- Data lanes are packed in vd_data and vs_data[0] as VecLanes x VecSumWidth.

Function
REQ-006 SHALL take the operation from instr[14:12]: 000 BCAST, 001 SETB, 010 LOADB, 011 APPLY; other codes are invalid.
REQ-007 SHALL take vlen from instr[25 +: VecLenWidth]; vlen is clamped to VecLanes.
REQ-008 SHALL make decode combinational and stateless: dec_rsp_valid = dec_req_valid; dec_req_ready = dec_rsp_valid && dec_rsp_ready; dec_rsp.id = dec_req.id.
REQ-009 SHALL drive decode flags as follows.
- accept = 1 for valid codes, 0 otherwise.
- rd_clobber = 0.
- vd_clobber = 1 only for BCAST and APPLY.
- rs_read[0] = 1 for BCAST and SETB.
- vs_read[0] = 1 for LOADB and APPLY.
- rs_read[1] and vs_read[1..2] = 0.
REQ-010 SHALL keep a per-lane bias register file of VecLanes x VecSumWidth.
REQ-011 SHALL implement execute as an FSM with states IDLE, BUSY and RESP.
REQ-012 IDLE: exe_req_ready = 1; on exe_req_valid, capture id, op, vlen, rs_data[0] and vs_data[0], clear the chunk counter, go to BUSY.
REQ-013 BUSY: each cycle process lanes [c*LanesPerCycle, (c+1)*LanesPerCycle) that are below vlen, then increment c.
REQ-014 BUSY SHALL go to RESP after ceil(vlen/LanesPerCycle) cycles; vlen = 0 SHALL spend exactly one BUSY cycle with no lane updates.
REQ-015 RESP: exe_rsp_valid = 1 with the registered result held stable until exe_rsp_ready; on the handshake, go to IDLE.
REQ-016 exe_req_ready SHALL be 0 in BUSY and RESP, so there is no overlap: there is one IDLE cycle between operations.
REQ-017 Latency: with acceptance at cycle 0, exe_rsp_valid SHALL rise at cycle max(1, ceil(vlen/LanesPerCycle)) + 1... (see REQ-014: one registered BUSY stage per chunk, then RESP).
REQ-018 BCAST: vd lane i = rs_data[0] truncated to VecSumWidth.
REQ-019 SETB: bias lane i = rs_data[0] truncated.
REQ-020 LOADB: bias lane i = vs_data[0] lane i.
REQ-021 APPLY: vd lane i = vs_data[0] lane i + bias lane i.
- Computed at VecSumWidth+1 signed.
- Saturate = 1: clamp to [-2^(VecSumWidth-1), 2^(VecSumWidth-1)-1].
- Saturate = 0: truncate.
REQ-022 SHALL set vd lanes at or above vlen, and all vd lanes for SETB and LOADB, to 0; bias lanes at or above vlen SHALL be unchanged.
REQ-023 exe_rsp.id SHALL equal the captured id; all other exe_rsp fields SHALL be 0.
REQ-024 An APPLY following SETB or LOADB SHALL see the updated bias, because execution is serialised.
REQ-025 An invalid op reaching execute SHALL complete as a no-op with zero vd and no bias change.

Reset
REQ-026 While rst = 1, the block SHALL hold the following values.
- FSM in IDLE; chunk counter 0.
- All bias lanes 0; result register 0.
- exe_rsp_valid = 0; exe_req_ready = 1 after deassertion.
REQ-027 Reset in BUSY or RESP SHALL abandon the operation: no response is issued and bias is cleared.

Structure
REQ-028 VecLanes, VecSumWidth/VecSumT, VecLenWidth/VecLenT and a VbiasOpE enum SHALL live in xadac_pkg.
REQ-029 Per-lane add/saturate SHALL be a combinational sub-module xadac_vbias_lane, instantiated LanesPerCycle times.

Verification
(Bench configuration: VecLanes = 8, VecSumWidth = 16, LanesPerCycle = 4, Saturate = 1.)
REQ-030 BCAST, vlen = 5, rs0 = 0x1_0003, id = 7 -> after 2 BUSY cycles, rsp id 7, lanes 0-4 = 0x0003, lanes 5-7 = 0.
REQ-031 SETB rs0 = 0x0010, vlen = 8; then APPLY vs0 lanes = 0x7FF8, vlen = 8 -> all lanes 0x7FFF (saturated); with Saturate = 0 -> 0x8008.
REQ-032 LOADB vs0 lanes = {1,2,...,8}, vlen = 3; then APPLY vs0 = 0, vlen = 8 -> lanes {1,2,3,0,0,0,0,0}.
REQ-033 APPLY vlen = 0 -> rsp at cycle 2 with all-zero vd; exe_rsp_ready held low 5 cycles -> rsp stable, exe_req_ready stays 0.
REQ-034 Assert rst during BUSY of a SETB -> no rsp, bias all 0; next APPLY vs0 = 5 -> lanes 5.
REQ-035 Decode funct3 = 111 -> accept = 0; decode BCAST -> rs_read[0] = 1, vd_clobber = 1, vs_read all 0.
